// File: rtl/pc_unit.sv
// Program-counter unit: sequential step, PC-relative branch, absolute jump, and
// call/return through a circular return-address stack built when PC_RAS_EN is defined.
module pc_unit #(
    parameter int ADDR_W     = 9,
    parameter int STEP       = 4,
    parameter int RESET_ADDR = 0,
    parameter int RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [2:0]        cmd,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] offset,
    output logic [ADDR_W-1:0] address,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam logic [2:0] CMD_BRANCH = 3'd1;
    localparam logic [2:0] CMD_JUMP   = 3'd2;
    localparam logic [2:0] CMD_CALL   = 3'd3;
    localparam logic [2:0] CMD_RET    = 3'd4;

    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] next_addr;

    assign seq_addr = address + ADDR_W'(STEP);

`ifdef PC_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    if (RAS_DEPTH < 2) begin : g_depth_check
        $error("pc_unit: RAS_DEPTH must be at least 2");
    end

    logic [ADDR_W-1:0] stk [RAS_DEPTH];
    logic [PW-1:0]     sp;       // next slot to write; top of stack is sp-1
    logic [PW-1:0]     sp_inc;
    logic [PW-1:0]     sp_dec;
    logic [CW-1:0]     cnt;
    logic              push;
    logic              pop;
    logic              ovf_nxt;
    logic              unf_nxt;
    logic              full;
    logic              empty;

    assign full   = (cnt == CW'(RAS_DEPTH));
    assign empty  = (cnt == '0);
    assign sp_inc = (sp == PW'(RAS_DEPTH - 1)) ? '0 : sp + PW'(1);
    assign sp_dec = (sp == '0) ? PW'(RAS_DEPTH - 1) : sp - PW'(1);

    always_comb begin
        next_addr = seq_addr;
        push      = 1'b0;
        pop       = 1'b0;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        case (cmd)
            CMD_BRANCH: next_addr = address + offset;
            CMD_JUMP:   next_addr = target;
            CMD_CALL: begin
                next_addr = target;
                push      = 1'b1;
                ovf_nxt   = full;
            end
            CMD_RET: begin
                if (!empty) begin
                    next_addr = stk[sp_dec];
                    pop       = 1'b1;
                end else begin
                    unf_nxt   = 1'b1;
                end
            end
            default: next_addr = seq_addr;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address <= ADDR_W'(RESET_ADDR);
            sp      <= '0;
            cnt     <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
            if (!stall) begin
                address <= next_addr;
                ras_ovf <= ovf_nxt;
                ras_unf <= unf_nxt;
                // a push onto a full stack overwrites the oldest slot, count saturates
                if (push) begin
                    sp <= sp_inc;
                    if (!full) cnt <= cnt + CW'(1);
                end else if (pop) begin
                    sp  <= sp_dec;
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    // Stack storage needs no reset; only the count decides what is valid.
    always_ff @(posedge clk) begin
        if (!stall && push) stk[sp] <= seq_addr;
    end

    assign ras_empty = empty;
    assign ras_full  = full;
`else
    always_comb begin
        next_addr = seq_addr;
        case (cmd)
            CMD_BRANCH: next_addr = address + offset;
            CMD_JUMP,
            CMD_CALL:   next_addr = target;
            default:    next_addr = seq_addr;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      address <= ADDR_W'(RESET_ADDR);
        else if (!stall) address <= next_addr;
    end

    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Randomized bench for pc_unit against a queue-based reference model; adapts to
// whether PC_RAS_EN is defined.
module tb_pc_unit;

    localparam int AW    = 9;
    localparam int DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic [2:0]    cmd;
    logic [AW-1:0] target;
    logic [AW-1:0] offset;
    logic [AW-1:0] address;
    logic          ras_empty, ras_full, ras_ovf, ras_unf;

    pc_unit #(.ADDR_W(AW), .STEP(4), .RESET_ADDR(0), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall(stall), .cmd(cmd),
        .target(target), .offset(offset), .address(address),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    int       m_addr;
    int       m_stk[$];
    bit       m_ovf, m_unf;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_addr = 0;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic void model_step(input int c, input int t, input int o, input bit s);
        m_ovf = 0;
        m_unf = 0;
        if (s) return;
        case (c)
            1: m_addr = (m_addr + o) % 512;
            2: m_addr = t;
            3: begin
                if (RAS) begin
                    if (m_stk.size() == DEPTH) begin
                        void'(m_stk.pop_front());
                        m_ovf = 1;
                    end
                    m_stk.push_back((m_addr + 4) % 512);
                end
                m_addr = t;
            end
            4: begin
                if (RAS && m_stk.size() > 0) m_addr = m_stk.pop_back();
                else begin
                    m_addr = (m_addr + 4) % 512;
                    m_unf  = RAS;
                end
            end
            default: m_addr = (m_addr + 4) % 512;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  int'(address),   m_addr);
        chk({tag, ".empty"}, int'(ras_empty), RAS ? int'(m_stk.size() == 0) : 1);
        chk({tag, ".full"},  int'(ras_full),  RAS ? int'(m_stk.size() == DEPTH) : 0);
        chk({tag, ".ovf"},   int'(ras_ovf),   int'(m_ovf));
        chk({tag, ".unf"},   int'(ras_unf),   int'(m_unf));
    endtask

    // inputs change just after an edge; outputs checked 1 time unit after the edge
    task automatic run(input string tag, input int c, input int t, input int o, input bit s);
        cmd    = 3'(c);
        target = AW'(t);
        offset = AW'(o);
        stall  = s;
        @(posedge clk);
        model_step(c, t, o, s);
        #1;
        check_all(tag);
    endtask

    // reset pulse placed between edges
    task automatic areset(input string tag);
        #1 reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; cmd = '0; target = '0; offset = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;

        for (int i = 0; i < 3; i++) run("seq", 0, 0, 0, 0);
        chk("seq3_const", int'(address), 12);

        run("jmp", 2, 'h1F8, 0, 0);
        run("wrap1", 0, 0, 0, 0);
        run("wrap2", 0, 0, 0, 0);
        chk("wrap_const", int'(address), 0);

        run("jmp40", 2, 'h40, 0, 0);
        run("br_neg", 1, 0, 'h1F0, 0);
        chk("br_const", int'(address), 'h30);

        run("jmp20", 2, 'h20, 0, 0);
        run("call", 3, 'h100, 0, 0);
        run("cs_seq", 0, 0, 0, 0);
        run("stall1", 4, 0, 0, 1);
        run("stall2", 3, 'h55, 0, 1);
        run("ret", 4, 0, 0, 0);
        chk("ret_const", int'(address), RAS ? 'h24 : 'h108);

        areset("rst_ovf");
        for (int i = 1; i <= 5; i++) run("call_ovf", 3, i * 'h40, 0, 0);
        for (int i = 0; i < 5; i++) run("ret_unf", 4, 0, 0, 0);
        chk("unf_const", int'(address), RAS ? 'h48 : 'h154);

        run("c1", 3, 'h80, 0, 0);
        run("c2", 3, 'hC0, 0, 0);
        areset("rst_mid");
        run("ret_after_rst", 4, 0, 0, 0);
        chk("rar_const", int'(address), 4);

        for (int n = 0; n < 2000; n++) begin
            int c;
            c = (($urandom_range(0, 9) < 6) ? int'($urandom_range(3, 4)) : int'($urandom_range(0, 7)));
            if ($urandom_range(0, 99) == 0) areset("rnd_rst");
            run("rnd", c, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                $urandom_range(0, 4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
